// File: rtl/psum_feeder.sv
// rtl/psum_feeder.sv - psum SRAM read sequencer feeding the SFU accumulator (optional RELU step: PSUM_FEEDER_RELU_EN)
module psum_feeder #(
    parameter int psum_bw = 16,
    parameter int addr_bw = 11,
    parameter int num_acc = 9,
    parameter int num_out = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [psum_bw-1:0] thres_in,
    output logic               busy,
    output logic               done,
    output logic               mem_cen,
    output logic [addr_bw-1:0] mem_addr,
    input  logic [psum_bw-1:0] mem_rdata,
    output logic               sfu_reset,
    output logic               acc,
    output logic               relu,
    output logic [psum_bw-1:0] sfu_in,
    output logic [psum_bw-1:0] thres,
    input  logic [psum_bw-1:0] sfu_out,
    output logic               wb_valid,
    output logic [addr_bw-1:0] wb_addr,
    output logic [psum_bw-1:0] wb_data
);

    localparam int KW = (num_acc > 1) ? $clog2(num_acc) : 1;
    localparam int OW = (num_out > 1) ? $clog2(num_out) : 1;
    localparam logic [KW-1:0]      K_LAST = KW'(num_acc - 1);
    localparam logic [OW-1:0]      O_LAST = OW'(num_out - 1);
    localparam logic [addr_bw-1:0] NOUT_A = addr_bw'(num_out);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RD,
        DRAIN,
        RELU,
        WB,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [KW-1:0]      k, k_n;
    logic [OW-1:0]      o, o_n;
    logic [psum_bw-1:0] thres_r, thres_n;

    // State, counters and latched threshold register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            k       <= '0;
            o       <= '0;
            thres_r <= '0;
        end else begin
            state   <= state_n;
            k       <= k_n;
            o       <= o_n;
            thres_r <= thres_n;
        end
    end

    // Next-state and counter sequencing; start only matters in IDLE
    always_comb begin
        state_n = state;
        k_n     = k;
        o_n     = o;
        thres_n = thres_r;
        case (state)
            IDLE: begin
                if (start) begin
                    thres_n = thres_in;
                    o_n     = '0;
                    state_n = CLR;
                end
            end
            CLR: begin
                k_n     = '0;
                state_n = RD;
            end
            RD: begin
                if (k == K_LAST) begin
                    k_n     = '0;
                    state_n = DRAIN;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            DRAIN: begin
`ifdef PSUM_FEEDER_RELU_EN
                state_n = RELU;
`else
                state_n = WB;
`endif
            end
            RELU: state_n = WB;
            WB: begin
                if (o == O_LAST) begin
                    state_n = DONE;
                end else begin
                    o_n     = o + 1'b1;
                    state_n = CLR;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes decoded from state only; acc trails each read issue by the SRAM latency
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign sfu_reset = (state == CLR);
    assign acc       = ((state == RD) && (k != '0)) || (state == DRAIN);
`ifdef PSUM_FEEDER_RELU_EN
    assign relu      = (state == RELU);
`else
    assign relu      = 1'b0;
`endif
    assign wb_valid  = (state == WB);
    assign mem_cen   = (state != RD);
    assign mem_addr  = (state == RD) ? (addr_bw'(k) * NOUT_A) + addr_bw'(o) : '0;
    assign wb_addr   = addr_bw'(o);
    assign sfu_in    = mem_rdata;
    assign thres     = thres_r;
    assign wb_data   = sfu_out;

endmodule

// File: tb/tb_psum_feeder.sv
// tb/tb_psum_feeder.sv - self-checking bench for psum_feeder with SRAM and SFU models
module tb_psum_feeder;

    localparam int PB = 16;
    localparam int AB = 11;
    localparam int NA = 9;
    localparam int NO = 16;
`ifdef PSUM_FEEDER_RELU_EN
    localparam int EXP_CYC = NO * (NA + 4) + 1;
`else
    localparam int EXP_CYC = NO * (NA + 3) + 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [PB-1:0] thres_in = '0;
    logic          busy, done, mem_cen, sfu_reset, acc, relu, wb_valid;
    logic [AB-1:0] mem_addr, wb_addr;
    logic [PB-1:0] mem_rdata = '0;
    logic [PB-1:0] sfu_in, thres, wb_data;
    logic [PB-1:0] sfu_acc = '0;

    psum_feeder #(.psum_bw(PB), .addr_bw(AB), .num_acc(NA), .num_out(NO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .thres_in(thres_in),
        .busy(busy), .done(done), .mem_cen(mem_cen), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .sfu_reset(sfu_reset), .acc(acc), .relu(relu),
        .sfu_in(sfu_in), .thres(thres), .sfu_out(sfu_acc), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // psum SRAM model: one-cycle read latency
    logic [PB-1:0] mem [NA*NO];
    always @(posedge clk) if (!mem_cen) mem_rdata <= mem[mem_addr];

    // SFU model: clear, accumulate, relu against threshold
    always @(posedge clk) begin
        if (sfu_reset) sfu_acc <= '0;
        else if (acc) sfu_acc <= sfu_acc + sfu_in;
        else if (relu) sfu_acc <= ($signed(sfu_acc) > $signed(thres)) ? sfu_acc : '0;
    end

    function automatic logic [PB-1:0] word(input int p, input int k, input int o);
        case (p)
            0:       return 16'd1;
            1:       return 16'hFFFF;
            2:       return 16'(o);
            default: return 16'(k - o);
        endcase
    endfunction

    function automatic logic [PB-1:0] exp_val(input int p, input int o, input logic [PB-1:0] th);
        logic [PB-1:0] s = '0;
        for (int k = 0; k < NA; k++) s = s + word(p, k, o);
`ifdef PSUM_FEEDER_RELU_EN
        if (!($signed(s) > $signed(th))) s = '0;
`endif
        return s;
    endfunction

    typedef struct {
        logic [AB-1:0] a;
        logic [PB-1:0] d;
    } exp_t;
    exp_t sb[$];

    int            n_wb, n_clr, n_done, acc_viol, excl_viol;
    logic [AB-1:0] rd_q[$];
    logic [PB-1:0] wb_seen [NO];
    logic          prev_rd = 1'b0;

    // Output monitor: scoreboard pop on write-back, strobe bookkeeping
    always @(negedge clk) begin
        if (reset_n) begin
            if (acc !== prev_rd) acc_viol++;
            prev_rd = !mem_cen;
            if ((int'(acc) + int'(relu) + int'(sfu_reset) + int'(wb_valid)) > 1) excl_viol++;
            if (!mem_cen) rd_q.push_back(mem_addr);
            if (sfu_reset) n_clr++;
            if (done) n_done++;
            if (wb_valid) begin
                exp_t e;
                n_wb++;
                wb_seen[wb_addr[3:0]] = wb_data;
                if (sb.size() == 0) begin
                    check("wb_unexpected", 32'(wb_addr), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("wb_addr", 32'(wb_addr), 32'(e.a));
                    check("wb_data", 32'(wb_data), 32'(e.d));
                end
            end
        end else begin
            prev_rd = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_strobes"}, 32'({busy, done, sfu_reset, acc, relu, wb_valid, mem_cen}), 32'h1);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_thres"}, 32'(thres), 32'h0);
    endtask

    task automatic run_feed(input int p, input logic [PB-1:0] th, input int mid, input int abort,
                            output int dc);
        int c;
        for (int k = 0; k < NA; k++)
            for (int o = 0; o < NO; o++) mem[k*NO + o] = word(p, k, o);
        sb.delete();
        for (int o = 0; o < NO; o++) begin
            exp_t e;
            e.a = AB'(o);
            e.d = exp_val(p, o, th);
            sb.push_back(e);
        end
        n_wb = 0; n_clr = 0; n_done = 0;
        rd_q.delete();
        @(negedge clk);
        start = 1'b1;
        thres_in = th;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        dc = -1;
        while (c <= 400) begin
            if (done && dc < 0) dc = c;
            start = (c == mid);
            if (c == abort) begin
                reset_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                break;
            end
            if (dc > 0 && c >= dc + 2) break;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
    endtask

    typedef struct {
        int            pat;
        logic [PB-1:0] th;
        logic [PB-1:0] exp0;
        logic [PB-1:0] exp15;
        int            mo;
        logic [PB-1:0] expm;
    } vec_t;

    vec_t vecs [5];
    int   dc;

    initial begin
`ifdef PSUM_FEEDER_RELU_EN
        vecs[0] = '{0, 16'h0000, 16'h0009, 16'h0009, 7, 16'h0009};
        vecs[1] = '{1, 16'h0000, 16'h0000, 16'h0000, 7, 16'h0000};
        vecs[2] = '{2, 16'd45,   16'h0000, 16'h0087, 5, 16'h0000};
        vecs[3] = '{3, 16'hFFFD, 16'h0024, 16'h0000, 2, 16'h0012};
        vecs[4] = '{2, 16'd45,   16'h0000, 16'h0087, 6, 16'h0036};
`else
        vecs[0] = '{0, 16'h0000, 16'h0009, 16'h0009, 7, 16'h0009};
        vecs[1] = '{1, 16'h0000, 16'hFFF7, 16'hFFF7, 7, 16'hFFF7};
        vecs[2] = '{2, 16'd45,   16'h0000, 16'h0087, 5, 16'h002D};
        vecs[3] = '{3, 16'hFFFD, 16'h0024, 16'hFF9D, 2, 16'h0012};
        vecs[4] = '{2, 16'd45,   16'h0000, 16'h0087, 6, 16'h0036};
`endif
        acc_viol = 0;
        excl_viol = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_feed(vecs[i].pat, vecs[i].th, -1, -1, dc);
            check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(EXP_CYC));
            check($sformatf("v%0d_done_count", i), 32'(n_done), 32'd1);
            check($sformatf("v%0d_wb_count", i), 32'(n_wb), 32'(NO));
            check($sformatf("v%0d_clr_count", i), 32'(n_clr), 32'(NO));
            check($sformatf("v%0d_busy_after", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_sb_left", i), 32'(sb.size()), 32'd0);
            check($sformatf("v%0d_out0", i), 32'(wb_seen[0]), 32'(vecs[i].exp0));
            check($sformatf("v%0d_out15", i), 32'(wb_seen[15]), 32'(vecs[i].exp15));
            check($sformatf("v%0d_outm", i), 32'(wb_seen[vecs[i].mo]), 32'(vecs[i].expm));
            if (i == 0) begin
                check("rd_count", 32'(rd_q.size()), 32'(NA*NO));
                for (int k = 0; k < NA; k++)
                    check($sformatf("rd_addr_o1_k%0d", k), 32'(rd_q[NA + k]), 32'(1 + NO*k));
            end
        end

        // start pulsed mid-run must be ignored
        run_feed(0, 16'h0000, 50, -1, dc);
        check("mid_done_cycle", 32'(dc), 32'(EXP_CYC));
        check("mid_done_count", 32'(n_done), 32'd1);
        check("mid_wb_count", 32'(n_wb), 32'(NO));
        check("mid_sb_left", 32'(sb.size()), 32'd0);

        // reset mid-run aborts without done, then a clean run from o=0
        run_feed(2, 16'd45, -1, 100, dc);
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        sb.delete();
        run_feed(3, 16'hFFFD, -1, -1, dc);
        check("rerun_done_cycle", 32'(dc), 32'(EXP_CYC));
        check("rerun_wb_count", 32'(n_wb), 32'(NO));
        check("rerun_sb_left", 32'(sb.size()), 32'd0);
        check("rerun_first_rd", 32'(rd_q.size() > 0 ? rd_q[0] : 11'h7FF), 32'd0);

        check("acc_follows_read", 32'(acc_viol), 32'd0);
        check("strobe_exclusive", 32'(excl_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
